// File: rtl/audio_dac_sdm.sv
// Final audio output stage: one-entry sample buffer, offset-binary code selection
// and a first-order sigma-delta modulator updated once every DAC_FREQ_DIV clocks.
module audio_dac_sdm #(
  parameter int IN_WIDTH      = 16,
  parameter int DAC_BIT_WIDTH = 10,
  parameter int DAC_FREQ_DIV  = 5
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic [IN_WIDTH-1:0] IN_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                MUTE,
  output logic                TICK,
  output logic                DAC_OUT
);

  localparam int W  = DAC_BIT_WIDTH;
  localparam int CW = (DAC_FREQ_DIV > 1) ? $clog2(DAC_FREQ_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DAC_FREQ_DIV - 1);
  localparam logic [W-1:0]  MIDSCALE = {1'b1, {(W-1){1'b0}}};

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          pend_full_q, pend_full_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [W-1:0]  code_q, code_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          dac_q, dac_d;
  logic          tick_q;

  logic          tick;
  logic          accept;
  logic [W-1:0]  pend_code;
  logic [W-1:0]  sel;
  logic          unused_in_bits;

  // Only the top W bits of a sample ever reach the modulator.
  assign unused_in_bits = ^IN_DATA;

  // Flipping the sign bit of the truncated sample yields offset binary.
  assign pend_code = pend_q ^ MIDSCALE;

  assign IN_READY = !pend_full_q;
  assign TICK     = tick_q;
  assign DAC_OUT  = dac_q;

  always_comb begin
    tick      = (div_cnt_q == CNT_MAX);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    accept    = IN_VALID && !pend_full_q;

    sel = code_q;
    if (MUTE) begin
      sel = MIDSCALE;
    end else if (pend_full_q) begin
      sel = pend_code;
    end

    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    code_d      = code_q;
    acc_d       = acc_q;
    dac_d       = dac_q;

    // A full buffer is drained on a tick even when muted.
    if (tick) begin
      pend_full_d    = 1'b0;
      code_d         = sel;
      {dac_d, acc_d} = {1'b0, acc_q} + {1'b0, sel};
    end

    // Accept only happens with an empty buffer, so it never races the drain.
    if (accept) begin
      pend_full_d = 1'b1;
      pend_d      = IN_DATA[IN_WIDTH-1 -: W];
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      div_cnt_q   <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      code_q      <= MIDSCALE;
      acc_q       <= '0;
      dac_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      code_q      <= code_d;
      acc_q       <= acc_d;
      dac_q       <= dac_d;
      tick_q      <= tick;
    end
  end

endmodule

// File: tb/tb_audio_dac_sdm.sv
// Scoreboard bench for audio_dac_sdm: a transaction-level model predicts every
// modulator output bit from the running sum of selected codes.
module tb_audio_dac_sdm;
  localparam int IW  = 16;
  localparam int W   = 10;
  localparam int DIV = 5;
  localparam int MID = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, mute, in_ready, tick_o, dac_o;
  logic [IW-1:0] in_data;
  logic          rst1_n, in_ready1, tick1, dac1;

  audio_dac_sdm #(.IN_WIDTH(IW), .DAC_BIT_WIDTH(W), .DAC_FREQ_DIV(DIV)) dut (
    .CLK(clk), .RESET_n(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .MUTE(mute), .TICK(tick_o), .DAC_OUT(dac_o)
  );

  audio_dac_sdm #(.IN_WIDTH(IW), .DAC_BIT_WIDTH(W), .DAC_FREQ_DIV(1)) u_div1 (
    .CLK(clk), .RESET_n(rst1_n), .IN_DATA(16'h0000), .IN_VALID(1'b1),
    .IN_READY(in_ready1), .MUTE(1'b0), .TICK(tick1), .DAC_OUT(dac1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Offset-binary code: shift the signed sample into 0..2^16-1, keep top W bits.
  function automatic int ref_code(input logic [IW-1:0] d);
    return (int'($signed(d)) + 32768) >> (IW - W);
  endfunction

  // Reference model state
  bit            m_full;
  logic [IW-1:0] m_pend;
  int            m_code;
  longint        m_sum;
  int            m_cnt;
  bit            m_tick_reg;
  bit            m_accepted;
  int            exp_q[$];
  int            ones_cnt, tick_cnt;

  // Model: evaluated at the falling edge on the inputs the next rising edge will see.
  initial begin
    int     c;
    bit     t, acc;
    longint prev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_full = 0; m_pend = '0; m_code = MID; m_sum = 0; m_cnt = 0;
        m_tick_reg = 0; m_accepted = 0;
        exp_q.delete();
      end else begin
        check("in_ready", int'(in_ready), int'(!m_full));
        t   = (m_cnt == DIV - 1);
        acc = in_valid && !m_full;
        if (t) begin
          if (mute)        c = MID;
          else if (m_full) c = ref_code(m_pend);
          else             c = m_code;
          m_code = c;
          m_full = 0;
          prev   = m_sum;
          m_sum  = m_sum + c;
          // Carry count between ticks = change in floor(total / 2^W).
          exp_q.push_back(int'(m_sum / 1024 - prev / 1024));
        end
        if (acc) begin
          m_full = 1;
          m_pend = in_data;
        end
        m_accepted = acc;
        m_tick_reg = t;
        m_cnt      = (m_cnt + 1) % DIV;
      end
    end
  end

  // Monitor: pops one expectation per TICK strobe.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        check("tick", int'(tick_o), int'(m_tick_reg));
        if (tick_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dac_out: got %0d expected none (empty queue)", dac_o);
          end else begin
            e = exp_q.pop_front();
            check("dac_out", int'(dac_o), e);
          end
          ones_cnt += int'(dac_o);
          tick_cnt++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IW-1:0] d);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!m_accepted && k < 50);
    if (!m_accepted) check("send_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3);
    ones_cnt = 0;
    tick_cnt = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic prev_dac;
    rst_n = 1'b0; rst1_n = 1'b0; in_valid = 1'b0; mute = 1'b0; in_data = '0;
    idle(2);
    check("rst_dac_out", int'(dac_o), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_in_ready", int'(in_ready), 1);
    rst1_n = 1'b1;
    do_reset();

    // Midscale: alternating bitstream
    send(16'h0000);
    idle(6 * DIV);

    // Full scale: 1023 ones in 1024 ticks from acc=0
    do_reset();
    send(16'h7FFF);
    k = 0;
    while (tick_cnt < 1024 && k < 6000) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("density_ticks", tick_cnt, 1024);
    check("density_ones", ones_cnt, 1023);
    #(10 - 3 + 1);

    // Negative full scale, then -1
    send(16'h8000);
    idle(8 * DIV);
    send(16'hFFFF);
    idle(8 * DIV);

    // Back-to-back samples, then underrun
    send(16'h4000);
    send(16'hC123);
    idle(10 * DIV);

    // Mute while a full-scale sample is pending
    mute = 1'b1;
    send(16'h7FFF);
    idle(DIV + 1);
    mute = 1'b0;
    idle(4 * DIV);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || m_accepted) begin
        in_valid = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 7))
          0:       in_data = 16'h7FFF;
          1:       in_data = 16'h8000;
          2:       in_data = 16'hFFFF;
          3:       in_data = 16'h0000;
          default: in_data = 16'($urandom);
        endcase
      end
      mute = ($urandom_range(0, 15) == 0);
      idle(1);
    end
    in_valid = 1'b0;
    mute = 1'b0;

    // Mid-stream reset while TICK and DAC_OUT are both high
    send(16'h0000);
    k = 0;
    do begin
      @(posedge clk);
      #3;
      k++;
    end while (!(tick_o && dac_o) && k < 200);
    check("found_tick_high", int'(tick_o && dac_o), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_dac", int'(dac_o), 0);
    check("async_rst_tick", int'(tick_o), 0);
    check("async_rst_ready", int'(in_ready), 1);
    idle(2);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (!tick_o && k < 20);
    check("first_tick_delay", k, DIV);
    idle(3 * DIV);
    check("queue_drained", int'(exp_q.size() <= 1), 1);

    // Divider of one: tick every cycle, midscale alternates
    @(posedge clk);
    #2;
    prev_dac = dac1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      check("div1_tick", int'(tick1), 1);
      check("div1_alternate", int'(dac1 != prev_dac), 1);
      prev_dac = dac1;
    end
    #1;
    rst1_n = 1'b0;
    #1;
    check("div1_rst_tick", int'(tick1), 0);
    check("div1_rst_dac", int'(dac1), 0);
    check("div1_rst_ready", int'(in_ready1), 1);
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    @(posedge clk);
    #2;
    check("div1_first_tick", int'(tick1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_dac_sdm.md
Name: audio_dac_sdm

Overview:
- Final audio output stage of the cartridge: accepts signed mixed PCM samples from the sound mixer and drives a single 1-bit pin through an external RC filter.
- Converts each sample to a DAC_BIT_WIDTH-bit offset-binary code.
- Runs a first-order sigma-delta modulator at CLK / DAC_FREQ_DIV.
- Board config supplies DAC_BIT_WIDTH and DAC_FREQ_DIV (rev1: 10 and 5).

Parameters:
- IN_WIDTH, 16, width of signed two's-complement input sample.
- DAC_BIT_WIDTH, 10, quantisation width of modulator code; must be ≤ IN_WIDTH.
- DAC_FREQ_DIV, 5, modulator update divider; must be ≥ 1.

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- IN_DATA  in  IN_WIDTH  signed sample.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  block can accept a sample.
- MUTE  in  1  force midscale code at next tick.
- TICK  out  1  one-cycle strobe, modulator update cycle.
- DAC_OUT  out  1  sigma-delta bitstream to pin.

Behaviour:
- Reset (async assert, sync-released by upstream): div_cnt=0, pending empty, code_reg=2^(DAC_BIT_WIDTH-1) (512 for W=10), acc=0, DAC_OUT=0, TICK=0, IN_READY=1 in the first cycle after release. Asserting reset mid-stream discards pending sample and accumulator state.
- Divider:
  - div_cnt counts 0..DAC_FREQ_DIV-1 and wraps.
  - tick is asserted combinationally when div_cnt==DAC_FREQ_DIV-1.
  - TICK is registered tick, so it lags by one cycle.
  - DAC_FREQ_DIV=1: tick is asserted every cycle.
- Input buffer (one entry):
  - IN_READY = !pending_full (registered state, no combinational path from IN_VALID).
  - IN_VALID & IN_READY captures IN_DATA into pending and sets pending_full.
  - IN_DATA is ignored while IN_READY=0; upstream holds it.
- Code selection on tick, priority order:
  1. MUTE=1: sel = midscale. The pending sample is still consumed (cleared) if full.
  2. pending_full: sel = {~pend[IN_WIDTH-1], pend[IN_WIDTH-2 -: DAC_BIT_WIDTH-1]}. This is the top DAC_BIT_WIDTH bits with the MSB inverted (truncation, no rounding, no clipping needed). pending_full clears.
  3. Otherwise: sel = code_reg (repeat last sample on underrun).
  - code_reg <= sel.
- Simultaneous tick and accept:
  - If pending is empty at a tick, no sample is consumed. An accept in the same cycle fills pending for the next tick.
  - If pending is full at a tick, IN_READY=0 that cycle, so no accept occurs. IN_READY returns to 1 the following cycle.
- Modulator, on tick only:
  - {carry, acc} <= acc + sel, with acc DAC_BIT_WIDTH bits unsigned and wrapping modulo 2^W.
  - DAC_OUT <= carry.
  - DAC_OUT and acc are held between ticks.
- Latency: a sample accepted in cycle n, with pending empty, affects DAC_OUT in the cycle after the first tick at or after n+1.
- Density: from acc=0 with constant code c, DAC_OUT is 1 on exactly c of every 2^W ticks.

Test Plan:
- Reset, then IN_DATA=16'h0000 accepted, W=10, DIV=5 → code 512. DAC_OUT alternates 0,1,0,1 per tick; TICK period 5 CLK.
- IN_DATA=16'h7FFF held → code 1023. Exactly 1023 ones in 1024 ticks; the first tick after acc=0 outputs 0.
- IN_DATA=16'h8000 → code 0. DAC_OUT constantly 0. Then 16'hFFFF → code 511 (0x3FF>>… top bits 0x3FF, MSB inverted = 0x1FF).
- Feed two samples back-to-back with no tick between:
  - IN_READY drops after the first accept.
  - The second is accepted the cycle after the next tick.
  - Underrun (no IN_VALID) repeats the last code_reg.
- MUTE=1 with pending sample 16'h7FFF at a tick → code_reg=512, pending cleared, IN_READY=1 next cycle.
- Assert RESET_n low mid-stream between ticks:
  - DAC_OUT, TICK go 0 and IN_READY goes 1 immediately.
  - After release, the first TICK occurs DAC_FREQ_DIV cycles later.
  - Repeat with DAC_FREQ_DIV=1 → TICK constant 1.
